eth_rx_word_packer: RTL and testbench
=====================================

# eth_rx_word_packer

Receive-side width converter between the 8-bit AXI-stream output of the Ethernet MAC and the 64-bit host read stream. It packs received bytes into little-endian 64-bit words with byte-keep and frame-end markers. Words are buffered in a small single-clock FIFO, and the block handles overflow deterministically. Optionally it filters frames by destination MAC address. It is the counterpart of the transmit byte-serialiser: it sits on the MAC RX clock domain, upstream of the host-side RX clock-crossing FIFO.

## Interface
- FIFO_DEPTH, 16, word FIFO depth; power of two, ≥4
- DST_ADDR, 48'hAABBCCDDEEFF, station address accepted by the filter

- i_clk_125  in  1  MAC RX clock; everything is synchronous to it
- glbl_rst  in  1  reset; synchronous, active-high
- s_axis_tdata  in  8  received byte
- s_axis_tvalid  in  1  byte valid
- s_axis_tlast  in  1  last byte of frame
- s_axis_tready  out  1  constant 1; the MAC cannot be back-pressured
- m_axis_tdata  out  64  packed word; the first byte of each word is in [7:0]
- m_axis_tkeep  out  8  valid-byte mask, contiguous from bit 0
- m_axis_tvalid  out  1  word valid
- m_axis_tlast  out  1  last word of frame
- m_axis_tready  in  1  host accepts word
- o_frame_cnt  out  16  frames delivered intact; saturates at 16'hFFFF
- o_drop_cnt  out  16  frames filtered or truncated; saturates at 16'hFFFF

## Operation
- The packer register accumulates bytes at index 0..7.
- A word is committed on its 8th byte, or on a tlast byte.
- Unused upper bytes are zero. tkeep = (1<<n)-1 for n bytes.
- States:
  - HDR: first 6 bytes of a frame. Exists only with the filter compiled in.
  - RUN: normal packing.
  - DISCARD: drop bytes until tlast, then return to the start state.
- Commit rules (free = FIFO_DEPTH − occupancy):
  - A non-last word commits only if free ≥ 2.
  - A last word commits if free ≥ 1.
- If a commit is refused:
  - In the same cycle, push a terminator word {data 0, keep 8'h00, last 1} into the reserved slot.
  - Increment o_drop_cnt and enter DISCARD.
  - Downstream therefore always sees a closed frame; a zero-keep last beat means truncated.
- When a last word commits, increment o_frame_cnt.
- FIFO entry = {last, keep[7:0], data[63:0]} = 73 bits.
- The FIFO is first-word-fall-through. m_axis_* is driven from the FIFO head.
- A pop occurs on tvalid & tready.
- Simultaneous push and pop at full is allowed; occupancy is unchanged.
- Reset mid-frame:
  - The partial word and FIFO contents are discarded.
  - Bytes after reset are treated as the start of a new frame; there is no resynchronisation.
  - The MAC is reset by the same glbl_rst.
- Reset values:
  - m_axis_tvalid = 0; m_axis_tdata, m_axis_tkeep, m_axis_tlast = 0.
  - Both counters = 0.
  - State = start state; FIFO empty.

## Timing
- One byte accepted per cycle; throughput 8 bytes per word with no bubbles.
- Latency: the edge sampling a word's final byte writes the packer. The FIFO push happens on the next edge, and m_axis_tvalid is high after it. That is 2 clocks from byte acceptance to tvalid when the FIFO is empty.
- The commit decision uses occupancy registered before the push cycle, including any same-cycle pop.
- m_axis_tdata/tkeep/tlast must hold stable while tvalid & ~tready.

## Configuration
- RX_DST_FILTER_EN defined:
  - HDR checks bytes 0..5 against DST_ADDR (byte 0 = MSB) or against broadcast 48'hFFFFFFFFFFFF.
  - The decision is made on byte 5, before any word is committed.
  - On mismatch: enter DISCARD, increment o_drop_cnt, emit nothing.
  - A frame ending (tlast) before byte 5 is dropped and counted.
- RX_DST_FILTER_EN undefined: HDR is absent, every frame is packed, and DST_ADDR is unused.

## Structure
- Package eth_rx_pkg:
  - state enum {HDR, RUN, DISCARD}
  - BCAST_ADDR constant
  - FIFO entry width 73 and field offsets
- Sub-module sync_word_fifo: single-clock FWFT FIFO, parameter DEPTH. Outputs occupancy, full and empty.
- The packer, filter, commit logic and counters live in the top module.

## Test plan
- 16-byte frame 0x00..0x0F, tready=1 → 0x0706050403020100 keep FF, then 0x0F0E0D0C0B0A0908 keep FF last; o_frame_cnt=1.
- 13-byte frame 0x00..0x0C → second word 0x000000_0C0B0A0908 keep 8'h1F last.
- FIFO_DEPTH=16, tready=0, 200-byte frame → 15 data words plus terminator (keep 00, last 1); o_drop_cnt=1. Release tready → 16 words drain in order.
- Filter on:
  - dst 11:22:33:44:55:66 → no output, o_drop_cnt=1.
  - dst FF:FF:FF:FF:FF:FF 64-byte frame → 8 words, o_frame_cnt=1.
  - 4-byte frame → dropped, counted.
- Filter off, 1-byte frame 0xA5 → one word 0xA5 keep 8'h01 last.
- glbl_rst after 5 bytes of a frame → outputs 0, counters 0. A following 8-byte frame → one word keep FF last.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet RX byte-to-word packer.
// Holds the packer state enum, the broadcast address and the FIFO entry layout.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        HDR,
        RUN,
        DISCARD
    } state_t;

    localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

    // FIFO entry = {last, keep[7:0], data[63:0]}
    localparam int ENTRY_W  = 73;
    localparam int DATA_LSB = 0;
    localparam int KEEP_LSB = 64;
    localparam int LAST_BIT = 72;

    // Byte idx of a MAC address as it appears on the wire (byte 0 = MSB).
    function automatic logic [7:0] addr_byte(
        input logic [47:0] addr,
        input logic [2:0]  idx
    );
        return addr[47 - 8 * int'(idx) -: 8];
    endfunction

endpackage

// File: rtl/eth_rx_word_packer_if.sv
// AXI-stream style interfaces for the RX packer: 8-bit byte stream in and
// 64-bit keep/last word stream out, each with master and slave modports.
interface eth_rx_byte_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

interface eth_rx_word_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (
        output tdata, output tkeep, output tvalid, output tlast,
        input  tready
    );
    modport slave (
        input  tdata, input tkeep, input tvalid, input tlast,
        output tready
    );
endinterface

// File: rtl/sync_word_fifo.sv
// Single-clock first-word-fall-through FIFO; head is visible while not empty.
// Ports: i_clk, i_rst (sync, high), i_push/i_data, i_pop, o_data, o_count, o_full, o_empty.
module sync_word_fifo
    import eth_rx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ENTRY_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [AW:0]      o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_count = r_count;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

    // A push at full is legal when the head leaves in the same cycle.
    assign w_rd = i_pop & ~o_empty;
    assign w_wr = i_push & (~o_full | w_rd);

    // Zero when empty so the output bus reads 0 after reset.
    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/eth_rx_word_packer.sv
// Packs MAC RX bytes into little-endian 64-bit words with keep/last, buffered in a FIFO.
// Ports: i_clk_125, glbl_rst, s_axis (bytes in), m_axis (words out), o_frame_cnt, o_drop_cnt.
// Option: define RX_DST_FILTER_EN to drop frames whose destination is not DST_ADDR/broadcast.
module eth_rx_word_packer
    import eth_rx_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [47:0] DST_ADDR   = 48'hAABBCCDDEEFF
) (
    input  logic           i_clk_125,
    input  logic           glbl_rst,
    eth_rx_byte_if.slave   s_axis,
    eth_rx_word_if.master  m_axis,
    output logic [15:0]    o_frame_cnt,
    output logic [15:0]    o_drop_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] ONE = (CW+1)'(1);
    localparam logic [CW:0] TWO = (CW+1)'(2);

`ifdef RX_DST_FILTER_EN
    localparam state_t START = HDR;
`else
    localparam state_t START = RUN;
`endif

    state_t       r_state;
    logic [2:0]   r_idx;
    logic [63:0]  r_acc;
    logic         r_st_vld;
    logic [63:0]  r_st_data;
    logic [7:0]   r_st_keep;
    logic         r_st_last;
    logic [15:0]  r_frame_cnt;
    logic [15:0]  r_drop_cnt;

    logic [CW:0]        w_count;
    logic [CW:0]        w_free;
    logic               w_unused_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_ok;
    logic               w_refuse;
    logic               w_abort;
    logic               w_term;
    logic               w_push;
    logic [ENTRY_W-1:0] w_wr;
    logic [ENTRY_W-1:0] w_rd;
    logic               w_beat;
    logic               w_last;
    logic [63:0]        w_acc;
    logic [7:0]         w_keep;
    logic               w_flt_drop;
    logic [16:0]        w_drop_sum;

    assign s_axis.tready = 1'b1;
    assign w_beat = s_axis.tvalid;
    assign w_last = s_axis.tlast;

    assign w_acc  = r_acc | (64'(s_axis.tdata) << {r_idx, 3'b000});
    assign w_keep = 8'hFF >> (3'd7 - r_idx);

    // Occupancy before this push, credited with a same-cycle pop.
    assign w_pop  = m_axis.tvalid & m_axis.tready;
    assign w_free = (CW+1)'(FIFO_DEPTH) - w_count + (CW+1)'(w_pop);

    // Non-last words keep one slot in reserve for the frame terminator.
    assign w_ok     = r_st_vld & (r_st_last ? (w_free >= ONE) : (w_free >= TWO));
    assign w_refuse = r_st_vld & ~w_ok;
    assign w_abort  = w_refuse & ~r_st_last;
    assign w_term   = w_abort & (w_free >= ONE);
    assign w_push   = w_ok | w_term;
    assign w_wr     = w_ok ? {r_st_last, r_st_keep, r_st_data}
                           : {1'b1, 8'h00, 64'h0};

`ifdef RX_DST_FILTER_EN
    logic r_dm;
    logic r_bm;
    logic w_dm;
    logic w_bm;

    // Running match of the destination bytes seen so far.
    assign w_dm = ((r_idx == 3'd0) | r_dm) &
                  (s_axis.tdata == addr_byte(DST_ADDR, r_idx));
    assign w_bm = ((r_idx == 3'd0) | r_bm) &
                  (s_axis.tdata == addr_byte(BCAST_ADDR, r_idx));

    assign w_flt_drop = w_beat & ~w_abort & (r_state == HDR) &
                        ((r_idx < 3'd5) ? w_last : ~(w_dm | w_bm));
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^DST_ADDR;
    assign w_flt_drop   = 1'b0;
`endif

    assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_refuse) + 17'(w_flt_drop);

    always_ff @(posedge i_clk_125) begin
        if (glbl_rst) begin
            r_state     <= START;
            r_idx       <= '0;
            r_acc       <= '0;
            r_st_vld    <= 1'b0;
            r_st_data   <= '0;
            r_st_keep   <= '0;
            r_st_last   <= 1'b0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
`ifdef RX_DST_FILTER_EN
            r_dm        <= 1'b0;
            r_bm        <= 1'b0;
`endif
        end else begin
            r_st_vld <= 1'b0;

            if (w_ok && r_st_last && r_frame_cnt != 16'hFFFF) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

            if (w_abort) begin
                // Rest of this frame is dropped; a tlast now ends it already.
                r_acc   <= '0;
                r_idx   <= '0;
                r_state <= (w_beat && w_last) ? START : DISCARD;
            end else if (w_beat) begin
                unique case (r_state)
`ifdef RX_DST_FILTER_EN
                    HDR: begin
                        r_dm <= w_dm;
                        r_bm <= w_bm;
                        if (r_idx == 3'd5) begin
                            if (w_dm | w_bm) begin
                                if (w_last) begin
                                    r_st_vld  <= 1'b1;
                                    r_st_data <= w_acc;
                                    r_st_keep <= w_keep;
                                    r_st_last <= 1'b1;
                                    r_acc     <= '0;
                                    r_idx     <= '0;
                                end else begin
                                    r_acc   <= w_acc;
                                    r_idx   <= 3'd6;
                                    r_state <= RUN;
                                end
                            end else begin
                                r_acc <= '0;
                                r_idx <= '0;
                                if (!w_last) begin
                                    r_state <= DISCARD;
                                end
                            end
                        end else if (w_last) begin
                            r_acc <= '0;
                            r_idx <= '0;
                        end else begin
                            r_acc <= w_acc;
                            r_idx <= r_idx + 3'd1;
                        end
                    end
`endif
                    RUN: begin
                        if (r_idx == 3'd7 || w_last) begin
                            r_st_vld  <= 1'b1;
                            r_st_data <= w_acc;
                            r_st_keep <= w_keep;
                            r_st_last <= w_last;
                            r_acc     <= '0;
                            r_idx     <= '0;
                            if (w_last) begin
                                r_state <= START;
                            end
                        end else begin
                            r_acc <= w_acc;
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                    DISCARD: begin
                        if (w_last) begin
                            r_state <= START;
                        end
                    end
                    default: r_state <= START;
                endcase
            end
        end
    end

    sync_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk   (i_clk_125),
        .i_rst   (glbl_rst),
        .i_push  (w_push),
        .i_data  (w_wr),
        .i_pop   (w_pop),
        .o_data  (w_rd),
        .o_count (w_count),
        .o_full  (w_unused_full),
        .o_empty (w_empty)
    );

    assign m_axis.tvalid = ~w_empty;
    assign m_axis.tdata  = w_rd[DATA_LSB +: 64];
    assign m_axis.tkeep  = w_rd[KEEP_LSB +: 8];
    assign m_axis.tlast  = w_rd[LAST_BIT];

    assign o_frame_cnt = r_frame_cnt;
    assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_eth_rx_word_packer.sv
// Directed bench for eth_rx_word_packer with immediate-assertion checks.
// Build with RX_DST_FILTER_EN defined to run the filter sequence instead.
module tb_eth_rx_word_packer;

    logic        clk;
    logic        rst;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
    int          n_checks;
    int          n_errors;
    logic [72:0] q[$];

    eth_rx_byte_if s_if ();
    eth_rx_word_if m_if ();

    eth_rx_word_packer dut (
        .i_clk_125   (clk),
        .glbl_rst    (rst),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .o_frame_cnt (frame_cnt),
        .o_drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Record every accepted output beat.
    always @(negedge clk) begin
        if (m_if.tvalid && m_if.tready) begin
            q.push_back({m_if.tlast, m_if.tkeep, m_if.tdata});
        end
    end

    function automatic logic [72:0] wd(
        input logic l, input logic [7:0] k, input logic [63:0] d
    );
        return {l, k, d};
    endfunction

    task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input string tag, input logic [72:0] exp);
        logic [72:0] got;
        got = '0;
        if (q.size() > 0) got = q.pop_front();
        chk(tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        s_if.tdata  = b;
        s_if.tvalid = 1'b1;
        s_if.tlast  = l;
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic send_seq(input int start, input int n);
        for (int i = 0; i < n; i++) send_byte(8'(start + i), i == n - 1);
    endtask

    task automatic send_hdr(input logic [47:0] a, input int n_pay, input int base);
        for (int i = 0; i < 6; i++) begin
            send_byte(a[47 - 8 * i -: 8], (n_pay == 0) && (i == 5));
        end
        for (int i = 0; i < n_pay; i++) send_byte(8'(base + i), i == n_pay - 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] d;
        n_checks = 0;
        n_errors = 0;
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        rst = 1'b0;
        #1;
        do_reset();

        chk("rst_tvalid", 73'(m_if.tvalid), 73'd0);
        chk("rst_word", {m_if.tlast, m_if.tkeep, m_if.tdata}, 73'd0);
        chk("rst_frame_cnt", 73'(frame_cnt), 73'd0);
        chk("rst_drop_cnt", 73'(drop_cnt), 73'd0);
        chk("rst_s_tready", 73'(s_if.tready), 73'd1);

`ifdef RX_DST_FILTER_EN
        q.delete();
        send_hdr(48'h112233445566, 10, 0);
        idle(6);
        chk("flt_miss_drop", 73'(drop_cnt), 73'd1);
        chk("flt_miss_frame", 73'(frame_cnt), 73'd0);
        chk("flt_miss_q", 73'(q.size()), 73'd0);

        send_hdr(48'hFFFFFFFFFFFF, 58, 6);
        idle(6);
        chk("flt_bc_n", 73'(q.size()), 73'd8);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) begin
                d[8*j +: 8] = (8 * k + j < 6) ? 8'hFF : 8'(8 * k + j);
            end
            expect_word($sformatf("flt_bc_w%0d", k), wd(k == 7, 8'hFF, d));
        end
        chk("flt_bc_frame", 73'(frame_cnt), 73'd1);

        send_seq(1, 4);
        idle(6);
        chk("flt_short_drop", 73'(drop_cnt), 73'd2);
        chk("flt_short_q", 73'(q.size()), 73'd0);

        send_hdr(48'hAABBCCDDEEFF, 2, 1);
        idle(6);
        expect_word("flt_own", wd(1'b1, 8'hFF, 64'h0201FFEEDDCCBBAA));
        chk("flt_own_frame", 73'(frame_cnt), 73'd2);

        send_hdr(48'hAABBCCDDEEFF, 0, 0);
        idle(6);
        expect_word("flt_hdr_only", wd(1'b1, 8'h3F, 64'h0000FFEEDDCCBBAA));
        chk("flt_hdr_frame", 73'(frame_cnt), 73'd3);
        chk("flt_end_drop", 73'(drop_cnt), 73'd2);
`else
        q.delete();
        send_seq(0, 16);
        idle(6);
        expect_word("f16_w0", wd(1'b0, 8'hFF, 64'h0706050403020100));
        expect_word("f16_w1", wd(1'b1, 8'hFF, 64'h0F0E0D0C0B0A0908));
        chk("f16_q", 73'(q.size()), 73'd0);
        chk("f16_frame", 73'(frame_cnt), 73'd1);

        send_seq(0, 13);
        idle(6);
        expect_word("f13_w0", wd(1'b0, 8'hFF, 64'h0706050403020100));
        expect_word("f13_w1", wd(1'b1, 8'h1F, 64'h0000000C0B0A0908));
        chk("f13_frame", 73'(frame_cnt), 73'd2);

        m_if.tready = 1'b0;
        send_seq(0, 200);
        idle(4);
        chk("ovf_drop", 73'(drop_cnt), 73'd1);
        chk("ovf_frame", 73'(frame_cnt), 73'd2);
        chk("ovf_q_held", 73'(q.size()), 73'd0);
        m_if.tready = 1'b1;
        idle(24);
        chk("ovf_n", 73'(q.size()), 73'd16);
        for (int k = 0; k < 15; k++) begin
            for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'(8 * k + j);
            expect_word($sformatf("ovf_w%0d", k), wd(1'b0, 8'hFF, d));
        end
        expect_word("ovf_term", wd(1'b1, 8'h00, 64'h0));

        m_if.tready = 1'b0;
        send_byte(8'hA5, 1'b1);
        chk("lat_1clk", 73'(m_if.tvalid), 73'd0);
        idle(1);
        chk("lat_2clk", 73'(m_if.tvalid), 73'd1);
        chk("one_word", {m_if.tlast, m_if.tkeep, m_if.tdata},
            wd(1'b1, 8'h01, 64'hA5));
        idle(3);
        chk("one_hold", {m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata[62:0]},
            {1'b1, 1'b1, 8'h01, 63'hA5});
        m_if.tready = 1'b1;
        idle(2);
        expect_word("one_pop", wd(1'b1, 8'h01, 64'hA5));
        chk("one_frame", 73'(frame_cnt), 73'd3);

        m_if.tready = 1'b0;
        send_seq(8'h20, 8);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 1'b0);
        idle(2);
        chk("pre_rst_frame", 73'(frame_cnt), 73'd4);
        chk("pre_rst_tvalid", 73'(m_if.tvalid), 73'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_tvalid", 73'(m_if.tvalid), 73'd0);
        chk("mid_rst_word", {m_if.tlast, m_if.tkeep, m_if.tdata}, 73'd0);
        chk("mid_rst_cnts", 73'({frame_cnt, drop_cnt}), 73'd0);
        m_if.tready = 1'b1;
        q.delete();
        send_seq(8'h10, 8);
        idle(6);
        expect_word("post_rst_w", wd(1'b1, 8'hFF, 64'h1716151413121110));
        chk("post_rst_q", 73'(q.size()), 73'd0);
        chk("post_rst_frame", 73'(frame_cnt), 73'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
